keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Front end of the fixed-point calculator: scans a 4x4 active-low key matrix and debounces it. Each accepted key press becomes exactly one single-cycle pulse of the 10-bit button code that `math_calculator_fsm` consumes on its `button` input. Between presses `button` is all zeros. It is the producer side of the calculator's button interface and connects directly to that port.

## Interface
- SCAN_DIV, 1000, clock cycles each column is driven; minimum 4.
- DEBOUNCE, 4, consecutive identical full-matrix frames required to accept a press or a release; minimum 1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- col_n  out  4  column drive, one-cold: exactly one bit is low, and that is the driven column.
- row_n  in  4  raw row sense, active-low, externally pulled up, asynchronous to clk.
- button  out  10  calculator button code; nonzero for exactly one cycle per accepted press.
- key_valid  out  1  high in the same cycle as a nonzero `button`.
- key_idx  out  4  index of the accepted key; holds its value until the next accepted press.

## Operation
- Key index = 4*row + col. A key is pressed when `row_n[row]` is low while `col_n[col]` is low.
- Code map:
  - idx 0-9 (digits 0-9): code 1<<idx, for example digit 5 = 10'b00_0010_0000.
  - idx 10 add = 10'b10_0000_0001.
  - idx 11 sub = 10'b10_0000_0010.
  - idx 12 mul = 10'b10_0000_0100.
  - idx 13 div = 10'b10_0000_1000.
  - idx 14 equal = 10'b11_0000_0000.
  - idx 15 clear = 10'b11_1000_0000.
- `row_n` passes through a 2-flop synchronizer. Its reset value is 4'b1111 (released).
- A dwell counter counts 0..SCAN_DIV-1 for each column. On the last dwell cycle the block:
  - samples the synchronized rows into that column's 4 bits of a 16-bit snapshot;
  - advances the column 0→1→2→3→0.
- The snapshot completes when column 3 is sampled (end of frame). Frame classes:
  - NONE: no key set.
  - ONE(k): exactly one key set.
  - MULTI: two or more keys set.
- State machine, evaluated only at frame ends:
  - IDLE:
    - ONE(k): latch candidate k, set the match count to 1, go to DEBOUNCE. If DEBOUNCE=1, go straight to EMIT.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - ONE(same k): increment the count; when it reaches DEBOUNCE, go to EMIT.
    - ONE(different k): replace the candidate and set the count to 1.
    - NONE or MULTI: return to IDLE.
  - EMIT, one cycle, not frame-gated:
    - `button` = code(k), `key_valid` = 1, `key_idx` = k.
    - Go to HELD.
  - HELD:
    - NONE: increment the release count; when it reaches DEBOUNCE, go to IDLE.
    - Any key (ONE or MULTI): clear the release count.
- No auto-repeat. A held key produces exactly one pulse.
- A new press is only possible after a debounced release.

## Timing
- Reset values:
  - `col_n` = 4'b1110.
  - `button` = 0, `key_valid` = 0, `key_idx` = 0.
  - State IDLE; all counters 0; snapshot = 0.
- Reset takes effect asynchronously and at any point, including mid-DEBOUNCE or during EMIT; no pulse may follow a reset unless a full new debounce completes.
- `col_n` changes on the clock edge after a sample; rows have SCAN_DIV-1 cycles to settle before the next sample. Because the synchronizer adds 2 cycles, SCAN_DIV must be at least 4.
- Frame period = 4*SCAN_DIV cycles.
- Press latency: `button` and `key_valid` assert on the edge after the end of the DEBOUNCE-th consecutive matching frame. They are registered outputs and are high for exactly 1 cycle.
- Worst case from a stable press to the pulse: (DEBOUNCE+1)*4*SCAN_DIV + 4 cycles.
- Minimum spacing between two pulses: 2*DEBOUNCE frames (press debounce plus release debounce).

## Test plan
Run every scenario with SCAN_DIV=4 and DEBOUNCE=2.
- Press row1/col1 (idx 5) and hold for 5 frames → one pulse with `button` = 10'b00_0010_0000 and `key_idx` = 5; `button` is 0 in every other cycle.
- Press row3/col3 (idx 15) → `button` = 10'b11_1000_0000 for one cycle. Release for 2 frames, then press row3/col2 (idx 14) → `button` = 10'b11_0000_0000 for one cycle.
- Toggle idx 2 every 6 cycles for 4 frames, then hold it stable for 3 frames → no pulse during the bounce, then exactly one pulse of 10'b00_0000_0100.
- Hold idx 0 and idx 10 together for 6 frames → no pulse. Release idx 10 → one pulse of 10'b00_0000_0001 after 2 matching frames.
- Release for only 1 frame between two presses of idx 3 → only one pulse total. With a 2-frame release → two pulses.
- Assert `rst_n` low mid-DEBOUNCE on idx 8, then release reset with the key still held → outputs are 0 and `col_n` = 4'b1110 during reset. After reset, a fresh 2-frame debounce completes, then one pulse of 10'b01_0000_0000.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with frame-based debounce for the calculator front end.
// Each debounced press yields one single-cycle pulse of the calculator button code.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [9:0] button,
  output logic       key_valid,
  output logic [3:0] key_idx
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_EMIT, ST_HELD} state_t;

  logic [3:0]    row_sync1_reg, row_sync2_reg;
  logic [DW-1:0] dwell_reg;
  logic [1:0]    col_sel_reg;
  logic [15:0]   snapshot_reg;
  state_t        state_reg;
  logic [3:0]    cand_reg;
  logic [CW-1:0] match_cnt_reg, rel_cnt_reg;

  logic        sample_en, frame_end, is_none, is_one;
  logic [15:0] frame_snap;
  logic [3:0]  frame_key;

  function automatic logic [9:0] key_code(input logic [3:0] k);
    case (k)
      4'd10:   key_code = 10'b10_0000_0001;
      4'd11:   key_code = 10'b10_0000_0010;
      4'd12:   key_code = 10'b10_0000_0100;
      4'd13:   key_code = 10'b10_0000_1000;
      4'd14:   key_code = 10'b11_0000_0000;
      4'd15:   key_code = 10'b11_1000_0000;
      default: key_code = 10'b00_0000_0001 << k;
    endcase
  endfunction

  assign sample_en = (dwell_reg == DW'(SCAN_DIV - 1));
  assign frame_end = sample_en && (col_sel_reg == 2'd3);

  // The frame is classified with the column-3 sample folded in, the same cycle it is taken.
  always_comb begin
    frame_snap = snapshot_reg;
    for (int r = 0; r < 4; r++) begin
      frame_snap[{2'(r), col_sel_reg}] = ~row_sync2_reg[r];
    end
  end

  always_comb begin
    frame_key = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_snap[i]) frame_key = 4'(i);
    end
  end

  assign is_none = (frame_snap == 16'd0);
  assign is_one  = !is_none && ((frame_snap & (frame_snap - 16'd1)) == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sync1_reg <= 4'b1111;
      row_sync2_reg <= 4'b1111;
      dwell_reg     <= '0;
      col_sel_reg   <= 2'd0;
      col_n         <= 4'b1110;
      snapshot_reg  <= '0;
    end else begin
      row_sync1_reg <= row_n;
      row_sync2_reg <= row_sync1_reg;
      if (sample_en) begin
        dwell_reg    <= '0;
        col_sel_reg  <= col_sel_reg + 2'd1;
        col_n        <= {col_n[2:0], col_n[3]};
        snapshot_reg <= frame_snap;
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cand_reg      <= 4'd0;
      match_cnt_reg <= '0;
      rel_cnt_reg   <= '0;
      button        <= '0;
      key_valid     <= 1'b0;
      key_idx       <= 4'd0;
    end else begin
      button    <= '0;
      key_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (frame_end && is_one) begin
            cand_reg      <= frame_key;
            match_cnt_reg <= CW'(1);
            state_reg     <= (DEBOUNCE == 1) ? ST_EMIT : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (frame_end) begin
            if (is_one && frame_key == cand_reg) begin
              match_cnt_reg <= match_cnt_reg + 1'b1;
              if (match_cnt_reg + 1'b1 == CW'(DEBOUNCE)) state_reg <= ST_EMIT;
            end else if (is_one) begin
              cand_reg      <= frame_key;
              match_cnt_reg <= CW'(1);
            end else begin
              match_cnt_reg <= '0;
              state_reg     <= ST_IDLE;
            end
          end
        end
        ST_EMIT: begin
          button        <= key_code(cand_reg);
          key_valid     <= 1'b1;
          key_idx       <= cand_reg;
          match_cnt_reg <= '0;
          rel_cnt_reg   <= '0;
          state_reg     <= ST_HELD;
        end
        ST_HELD: begin
          // Any key seen, even an ambiguous multi-key frame, restarts the release count.
          if (frame_end) begin
            if (!is_none) begin
              rel_cnt_reg <= '0;
            end else if (rel_cnt_reg + 1'b1 == CW'(DEBOUNCE)) begin
              rel_cnt_reg <= '0;
              state_reg   <= ST_IDLE;
            end else begin
              rel_cnt_reg <= rel_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: expected pulses are queued when keys are pressed
// and popped when the scanner emits a button pulse.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n, row_n;
  logic [9:0] button;
  logic       key_valid;
  logic [3:0] key_idx;

  logic [15:0] keys_down = 16'd0;
  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned last_pulse_cyc = 0;
  int unsigned rel_cyc = 0;

  typedef struct {
    logic [9:0] code;
    logic [3:0] idx;
  } exp_t;
  exp_t exp_q[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .button(button), .key_valid(key_valid), .key_idx(key_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [9:0] tb_code(input int k);
    case (k)
      10: return 10'b10_0000_0001;
      11: return 10'b10_0000_0010;
      12: return 10'b10_0000_0100;
      13: return 10'b10_0000_1000;
      14: return 10'b11_0000_0000;
      15: return 10'b11_1000_0000;
      default: return 10'(1 << k);
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input int k);
    exp_t e;
    e.code = tb_code(k);
    e.idx  = 4'(k);
    exp_q.push_back(e);
  endtask

  // Return at the first negedge where the given column has just become driven.
  task automatic align_col(input logic [3:0] target);
    int n = 0;
    while (col_n == target && n < 100) begin @(negedge clk); n++; end
    while (col_n != target && n < 100) begin @(negedge clk); n++; end
    chk("align_col", col_n, target);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (key_valid || button != 10'd0)) begin
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {21'd0, key_valid, button}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("pulse: button=%b key_idx=%0d expected=%b/%0d", button, key_idx, e.code, e.idx);
        chk("button", button, e.code);
        chk("key_idx", key_idx, e.idx);
        chk("key_valid", key_valid, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout at t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    wait_cyc(3);
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_button", button, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_idx", key_idx, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Single press of digit 5, held well past debounce.
    keys_down = 16'h0001 << 5; expect_key(5);
    wait_cyc(5 * FRAME);
    keys_down = 16'd0;
    wait_cyc(4 * FRAME);
    chk("s1_pending", exp_q.size(), 0);

    // Clear, a 2-frame release, then equal.
    keys_down = 16'h0001 << 15; expect_key(15);
    wait_cyc(5 * FRAME);
    keys_down = 16'd0;
    wait_cyc(2 * FRAME);
    keys_down = 16'h0001 << 14; expect_key(14);
    wait_cyc(5 * FRAME);
    keys_down = 16'd0;
    wait_cyc(4 * FRAME);
    chk("s2_pending", exp_q.size(), 0);

    // Bounce on idx 2 phased so no two consecutive frames agree, then a stable hold.
    align_col(4'b1011);
    wait_cyc(2);
    for (int i = 0; i < 10; i++) begin
      keys_down = (i % 2 == 0) ? (16'h0001 << 2) : 16'd0;
      wait_cyc(6);
    end
    keys_down = 16'h0001 << 2; expect_key(2);
    wait_cyc(3 * FRAME);
    keys_down = 16'd0;
    wait_cyc(4 * FRAME);
    chk("s3_pending", exp_q.size(), 0);

    // Two keys together are ignored; releasing one leaves a clean single key.
    keys_down = (16'h0001 << 0) | (16'h0001 << 10);
    wait_cyc(6 * FRAME);
    chk("s4_multi_pending", exp_q.size(), 0);
    keys_down = 16'h0001; expect_key(0);
    wait_cyc(4 * FRAME);
    keys_down = 16'd0;
    wait_cyc(4 * FRAME);
    chk("s4_pending", exp_q.size(), 0);

    // Short release does not rearm; a 2-frame release does.
    keys_down = 16'h0001 << 3; expect_key(3);
    wait_cyc(4 * FRAME);
    keys_down = 16'd0;
    wait_cyc(FRAME);
    keys_down = 16'h0001 << 3;
    wait_cyc(4 * FRAME);
    chk("s5_short_release", exp_q.size(), 0);
    keys_down = 16'd0;
    wait_cyc(2 * FRAME);
    keys_down = 16'h0001 << 3; expect_key(3);
    wait_cyc(4 * FRAME);
    keys_down = 16'd0;
    wait_cyc(4 * FRAME);
    chk("s5_pending", exp_q.size(), 0);

    // Reset in the middle of debouncing idx 8, key still held afterwards.
    align_col(4'b1110);
    keys_down = 16'h0001 << 8;
    wait_cyc(24);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_col_n", col_n, 4'b1110);
    chk("s6_rst_button", button, 0);
    chk("s6_rst_key_valid", key_valid, 0);
    chk("s6_rst_key_idx", key_idx, 0);
    wait_cyc(3);
    chk("s6_rst_hold_col_n", col_n, 4'b1110);
    chk("s6_rst_hold_button", button, 0);
    expect_key(8);
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_cyc(5 * FRAME);
    chk("s6_latency", last_pulse_cyc - rel_cyc, 33);
    keys_down = 16'd0;
    wait_cyc(4 * FRAME);
    chk("s6_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
